// File: rtl/jk_pkg.sv
// Shared definitions for JK excitation drivers.
//   - jk_state_e    : driver FSM state encoding
//   - MODE_LOAD/... : request mode encodings
//   - jk_excite_bit : per-bit JK excitation with don't-cares resolved to 0
package jk_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSettle = 2'd2,
        StCheck  = 2'd3
    } jk_state_e;

    localparam logic MODE_LOAD   = 1'b0;
    localparam logic MODE_TOGGLE = 1'b1;

    // Returns {j, k}. A bit already at its target gets J=K=0 (hold), so J=K=1
    // can never be produced.
    function automatic logic [1:0] jk_excite_bit(input logic q, input logic e);
        return {e & ~q, ~e & q};
    endfunction

endpackage

// File: rtl/jk_excite_calc.sv
// Combinational WIDTH-bit JK excitation encoder.
// Ports:
//   i_q        current flop state
//   i_expected desired flop state
//   o_j/o_k    excitation (hold bits get J=K=0)
//   o_any      at least one bit needs excitation
module jk_excite_calc
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_expected,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k,
    output logic             o_any
);

    always_comb begin
        o_j = '0;
        o_k = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            {o_j[i], o_k[i]} = jk_excite_bit(i_q[i], i_expected[i]);
        end
        o_any = |(o_j | o_k);
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// JK excitation driver: accepts a target word (load) or toggle mask over a
// valid/ready handshake, pulses a JK bank with the derived J/K excitation,
// waits SETTLE_CYCLES, checks the readback and retries up to MAX_RETRY times.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tgt_valid/ready     request handshake
//   tgt_mode, tgt_data  0 = load data, 1 = toggle bits set in data
//   q_in                JK bank readback (synchronous to clk)
//   j_out/k_out/en_out  JK bank drive, en_out pulses once per attempt
//   busy                not idle
//   done/err            one-cycle completion pulses
//   err_bits            mismatching bits of the final failed check
//
// Optional: define JK_DRIVER_STATS_EN to add saturating 16-bit counters
//   stat_req (accepted requests), stat_retry (retry drives), stat_err (errors).
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic             tgt_mode,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             en_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
`ifdef JK_DRIVER_STATS_EN
    ,
    output logic [15:0]      stat_req,
    output logic [15:0]      stat_retry,
    output logic [15:0]      stat_err
`endif
);

    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [RW-1:0] MAX_RETRY_W   = RW'(MAX_RETRY);
    localparam logic [SW-1:0] SETTLE_LAST_W = SW'(SETTLE_CYCLES - 1);

    jk_state_e        r_state;
    logic [WIDTH-1:0] r_expected;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_en;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_err_bits;
    logic [RW-1:0]    r_retry;
    logic [SW-1:0]    r_settle;

    logic [WIDTH-1:0] w_new_expected;
    logic [WIDTH-1:0] w_calc_expected;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_any;
    logic             w_accept;
    logic             w_mismatch;
    logic             w_retry_fire;
    logic             w_err_fire;

    assign w_new_expected = (tgt_mode == MODE_TOGGLE) ? (q_in ^ tgt_data) : tgt_data;

    // One encoder serves both the acceptance edge (new target) and the retry
    // edge out of CHECK (stored target); the two never coincide.
    assign w_calc_expected = (r_state == StIdle) ? w_new_expected : r_expected;

    jk_excite_calc #(
        .WIDTH(WIDTH)
    ) u_calc (
        .i_q       (q_in),
        .i_expected(w_calc_expected),
        .o_j       (w_j),
        .o_k       (w_k),
        .o_any     (w_any)
    );

    assign tgt_ready    = (r_state == StIdle) && !rst;
    assign w_accept     = tgt_valid && tgt_ready;
    assign w_mismatch   = (q_in != r_expected);
    assign w_retry_fire = (r_state == StCheck) && w_mismatch && (r_retry != MAX_RETRY_W);
    assign w_err_fire   = (r_state == StCheck) && w_mismatch && (r_retry == MAX_RETRY_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_expected <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_bits <= '0;
            r_retry    <= '0;
            r_settle   <= '0;
        end else begin
            // Pulse outputs and drive lines default low every cycle.
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_en   <= 1'b0;
            r_j    <= '0;
            r_k    <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_expected <= w_new_expected;
                        r_retry    <= '0;
                        r_err_bits <= '0;
                        if (w_any) begin
                            r_state <= StDrive;
                            r_j     <= w_j;
                            r_k     <= w_k;
                            r_en    <= 1'b1;
                        end else begin
                            // Nothing to change: skip the drive and settle.
                            r_state <= StCheck;
                        end
                    end
                end
                StDrive: begin
                    r_state  <= StSettle;
                    r_settle <= '0;
                end
                StSettle: begin
                    if (r_settle == SETTLE_LAST_W) begin
                        r_state <= StCheck;
                    end else begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                StCheck: begin
                    if (!w_mismatch) begin
                        r_done  <= 1'b1;
                        r_state <= StIdle;
                    end else if (w_retry_fire) begin
                        // Retry is always a load of the stored target.
                        r_retry <= r_retry + 1'b1;
                        r_state <= StDrive;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_en    <= 1'b1;
                    end else begin
                        r_err      <= 1'b1;
                        r_err_bits <= q_in ^ r_expected;
                        r_state    <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign j_out    = r_j;
    assign k_out    = r_k;
    assign en_out   = r_en;
    assign busy     = (r_state != StIdle);
    assign done     = r_done;
    assign err      = r_err;
    assign err_bits = r_err_bits;

`ifdef JK_DRIVER_STATS_EN
    logic [15:0] r_stat_req;
    logic [15:0] r_stat_retry;
    logic [15:0] r_stat_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_req   <= '0;
            r_stat_retry <= '0;
            r_stat_err   <= '0;
        end else begin
            if (w_accept && (r_stat_req != 16'hFFFF)) begin
                r_stat_req <= r_stat_req + 16'd1;
            end
            if (w_retry_fire && (r_stat_retry != 16'hFFFF)) begin
                r_stat_retry <= r_stat_retry + 16'd1;
            end
            if (w_err_fire && (r_stat_err != 16'hFFFF)) begin
                r_stat_err <= r_stat_err + 16'd1;
            end
        end
    end

    assign stat_req   = r_stat_req;
    assign stat_retry = r_stat_retry;
    assign stat_err   = r_stat_err;
`endif

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Initiator side of the JK storage interface. Accepts a target word (or a toggle mask) over a valid/ready handshake.
- Derives per-bit J/K excitation from the current readback state and drives a bank of JK latches/flops with a one-cycle enable.
- After a settle window, checks the readback against the expected value, retries on mismatch, and reports done/err.
- Sits between control logic and any WIDTH-bit JK register bank.

Parameters:
- WIDTH, 8, number of JK bits driven.
- SETTLE_CYCLES, 2, cycles (>=1) waited after the enable pulse before readback is compared.
- MAX_RETRY, 3, extra drive attempts (>=0) after a failed check before err.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- tgt_valid  input  1  request valid.
- tgt_ready  output  1  request accepted when tgt_valid && tgt_ready at a clk edge.
- tgt_mode  input  1  0 = load tgt_data as target; 1 = toggle the bits set in tgt_data.
- tgt_data  input  WIDTH  target word or toggle mask.
- q_in  input  WIDTH  readback of JK bank Q.
- j_out  output  WIDTH  J drive.
- k_out  output  WIDTH  K drive.
- en_out  output  1  JK bank enable, one-cycle pulse per drive attempt.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle success pulse.
- err  output  1  one-cycle failure pulse.
- err_bits  output  WIDTH  q_in ^ expected from the final check; valid with err, held until next acceptance.

Behaviour:
- Reset values: state IDLE; j_out, k_out, en_out, done, err, err_bits, retry count all 0.
- tgt_ready = (state==IDLE) && !rst, combinational.
- Acceptance edge T0:
  - expected <= (mode 0) tgt_data, or (mode 1) q_in ^ tgt_data.
  - J/K computed from q_in sampled at T0, with don't-cares driven 0: j = expected & ~q, k = ~expected & q.
  - Bits already equal to expected get J=K=0 (hold). J=K=1 is never issued.
- Zero-excitation shortcut: if j|k == 0 at T0, go straight to CHECK (cycle 1); done in cycle 2. No en_out is issued.
- States: IDLE -> DRIVE -> SETTLE -> CHECK -> IDLE.
  - DRIVE (1 cycle): j_out/k_out registered with the computed values; en_out=1.
  - SETTLE (SETTLE_CYCLES cycles): j_out=k_out=0, en_out=0.
  - CHECK (1 cycle): compare q_in to expected.
    - Match: next cycle done=1, IDLE.
    - Mismatch and retries < MAX_RETRY: retries++. Next cycle DRIVE with J/K recomputed from q_in sampled in CHECK against expected; a toggle request is retried as a load of expected.
    - Mismatch and retries == MAX_RETRY: next cycle err=1, err_bits latched, IDLE.
- Nominal latency (no retry): DRIVE in cycle 1, SETTLE in cycles 2..S+1, CHECK in cycle S+2, done in cycle S+3. Default S=2 gives done 5 cycles after acceptance.
- Each retry adds S+2 cycles.
- done and err are never simultaneous.
- A new request can be accepted in the same cycle done/err is high, since IDLE and tgt_ready=1 hold that cycle.
- Retry counter width: max(1, clog2(MAX_RETRY+1)); it clears on acceptance.
- tgt_data and tgt_mode are ignored when not accepted; inputs may change while busy.
- rst mid-operation (any state): next edge forces IDLE.
  - j_out/k_out/en_out drop in the cycle after the reset edge.
  - No done/err pulse is produced.
  - The aborted request is lost.
- q_in is assumed synchronous to clk; no synchronizer is included.

Optional Feature:
- Macro: JK_DRIVER_STATS_EN.
- Defined: adds three outputs, all cleared by rst and saturating at all-ones:
  - stat_req[15:0]: accepted requests.
  - stat_retry[15:0]: retry drives.
  - stat_err[15:0]: err pulses.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package jk_pkg:
  - state enum encoding: IDLE=0, DRIVE=1, SETTLE=2, CHECK=3.
  - mode constants: MODE_LOAD=0, MODE_TOGGLE=1.
  - excitation function computing (j,k) from (q, expected) with don't-care = 0.
- One sub-module is natural: jk_excite_calc, a pure combinational WIDTH-bit excitation encoder, reusable by other JK drivers.
- FSM, counters and stats stay in the top module.

Test Plan:
- Load: q_in=0x00, request mode 0 data 0xA5; bench models the JK bank ideally -> DRIVE j=0xA5, k=0x00, en pulse cycle 1, done cycle 5, busy cycles 1-4.
- Toggle: q_in=0xF0, mode 1 mask 0x3C -> expected 0xCC, j=0x0C, k=0x30, done cycle 5.
- No-op: q_in=0x5A, load 0x5A -> en_out never asserted, done cycle 2.
- Retry then err: bank model ignores en, q_in stuck 0x00, load 0x01.
  - Expect 4 DRIVE pulses (MAX_RETRY=3).
  - Expect err at cycle 4*(S+2)+1=17 with err_bits=0x01.
- Retry success: bank misses the first en only -> second drive j=0x01, done at cycle 9.
- Reset mid-SETTLE: assert rst in cycle 2 -> IDLE next edge, no done/err; new request afterwards completes normally. With JK_DRIVER_STATS_EN, stat_req counts only post-reset requests.
